// File: rtl/exec_control.sv
// exec_control: multi-cycle execute/writeback sequencer.
// Sits directly after the fetch stage. It latches the fetched instruction,
// owns the four-entry register file, drives ALU operands, data-RAM
// write/address/data and PC increment/load strobes, and writes ALU results
// and RAM read data back into the register file.
//
// Instruction format: [15:12] opcode, [11:10] hi register, [9:8] lo register,
// [7:0] constant (RAM address or jump target).
// DATA_ADDR_WIDTH must not exceed 8 because the RAM address comes from the
// 8-bit constant field.
module exec_control #(
  parameter int INST_ADDR_WIDTH = 8,
  parameter int DATA_ADDR_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [15:0]                i_inst,
  input  logic [15:0]                i_alu_out,
  input  logic [15:0]                i_ram_data,
  output logic [15:0]                o_data1,
  output logic [15:0]                o_data2,
  output logic                       o_inc_pc,
  output logic                       o_load_pc,
  output logic [INST_ADDR_WIDTH-1:0] o_pc_addr,
  output logic                       o_ram_load,
  output logic [DATA_ADDR_WIDTH-1:0] o_ram_addr,
  output logic [15:0]                o_ram_data,
  output logic                       o_halted
);

  typedef enum logic [1:0] {
    STATE_FETCH = 2'd0,
    STATE_EXEC  = 2'd1,
    STATE_MEM   = 2'd2,
    STATE_HALT  = 2'd3
  } state_e;

  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] regs_q [4];

  logic [3:0]  opcode;
  logic [1:0]  hiSel;
  logic [1:0]  loSel;
  logic        isAluOp;
  logic        hiIsZero;

  logic        regWe;
  logic [15:0] regWdata;
  logic        incPc;
  logic        loadPc;
  logic        ramLoad;

  // Instruction field decode; everything downstream works from the latched IR.
  assign opcode   = ir_q[15:12];
  assign hiSel    = ir_q[11:10];
  assign loSel    = ir_q[9:8];
  assign isAluOp  = ~opcode[3];
  assign hiIsZero = (regs_q[hiSel] == 16'h0000);

  // Operands are read combinationally, so a writeback is visible to the very
  // next instruction's EXEC without any forwarding path.
  assign o_data1    = regs_q[hiSel];
  assign o_data2    = regs_q[loSel];
  assign o_ram_data = regs_q[hiSel];

  // Address outputs simply truncate the constant; PC wrap belongs to fetch.
  assign o_pc_addr  = ir_q[INST_ADDR_WIDTH-1:0];
  assign o_ram_addr = ir_q[DATA_ADDR_WIDTH-1:0];

  assign o_inc_pc   = incPc;
  assign o_load_pc  = loadPc;
  assign o_ram_load = ramLoad;
  assign o_halted   = (state_q == STATE_HALT);

  // Next-state, IR capture, writeback select and strobes; a low enable freezes
  // everything and suppresses strobes so a resumed state fires them exactly once.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    regWe    = 1'b0;
    regWdata = i_alu_out;
    incPc    = 1'b0;
    loadPc   = 1'b0;
    ramLoad  = 1'b0;

    if (i_en) begin
      case (state_q)
        STATE_FETCH: begin
          ir_d    = i_inst;
          state_d = STATE_EXEC;
        end

        STATE_EXEC: begin
          state_d = STATE_FETCH;
          if (isAluOp) begin
            regWe    = 1'b1;
            regWdata = i_alu_out;
            incPc    = 1'b1;
          end else begin
            case (opcode)
              OP_LOAD: begin
                incPc   = 1'b1;
                state_d = STATE_MEM;
              end
              OP_STORE: begin
                ramLoad = 1'b1;
                incPc   = 1'b1;
              end
              OP_JMP: begin
                loadPc = 1'b1;
              end
              OP_JZ: begin
                if (hiIsZero) begin
                  loadPc = 1'b1;
                end else begin
                  incPc = 1'b1;
                end
              end
              OP_HALT: begin
                state_d = STATE_HALT;
              end
              default: begin
                incPc = 1'b1;
              end
            endcase
          end
        end

        STATE_MEM: begin
          regWe    = 1'b1;
          regWdata = i_ram_data;
          state_d  = STATE_FETCH;
        end

        STATE_HALT: begin
          state_d = STATE_HALT;
        end

        default: begin
          state_d = STATE_FETCH;
        end
      endcase
    end
  end

  // FSM state and instruction register; reset lands in FETCH with a zero IR.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= STATE_FETCH;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Register file: one write port, always targeting reg[hi].
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < 4; k++) begin
        regs_q[k] <= 16'h0000;
      end
    end else if (regWe) begin
      regs_q[hiSel] <= regWdata;
    end
  end

endmodule

// File: tb/tb_exec_control.sv
// tb_exec_control: randomized self-checking bench for exec_control.
// Surrounds the DUT with a fetch stage (PC + instruction memory), an ALU and
// a one-cycle-read data RAM, and compares every cycle against an
// instruction-level reference model of the architecture.
module tb_exec_control;

  localparam int IAW = 8;
  localparam int DAW = 8;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_en;
  logic [15:0]    i_inst;
  logic [15:0]    i_alu_out;
  logic [15:0]    i_ram_data;
  logic [15:0]    o_data1;
  logic [15:0]    o_data2;
  logic           o_inc_pc;
  logic           o_load_pc;
  logic [IAW-1:0] o_pc_addr;
  logic           o_ram_load;
  logic [DAW-1:0] o_ram_addr;
  logic [15:0]    o_ram_data;
  logic           o_halted;

  exec_control #(.INST_ADDR_WIDTH(IAW), .DATA_ADDR_WIDTH(DAW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_inst(i_inst),
    .i_alu_out(i_alu_out), .i_ram_data(i_ram_data),
    .o_data1(o_data1), .o_data2(o_data2), .o_inc_pc(o_inc_pc),
    .o_load_pc(o_load_pc), .o_pc_addr(o_pc_addr), .o_ram_load(o_ram_load),
    .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data), .o_halted(o_halted)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Environment: instruction memory, fetch PC, data RAM.
  logic [15:0] imem [256];
  logic [15:0] ramInit [256];
  logic [15:0] envRam [256];
  logic [7:0]  envPc;
  logic [15:0] ramRd;
  logic        fillRam;

  // Reference model architectural state.
  logic [15:0] mRegs [4];
  logic [15:0] mRam [256];
  logic [7:0]  mPc;
  bit          mHalted;

  typedef struct {
    bit          incPc;
    bit          loadPc;
    bit          ramLoad;
    bit          halted;
    bit          chkData;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [7:0]  addr;
  } cycleExp_t;

  // The bench's ALU: opcode low three bits pick the operation.
  function automatic logic [15:0] aluFn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op[2:0])
      3'd0:    aluFn = a + b;
      3'd1:    aluFn = a - b;
      3'd2:    aluFn = a & b;
      3'd3:    aluFn = a | b;
      3'd4:    aluFn = a ^ b;
      3'd5:    aluFn = ~a;
      3'd6:    aluFn = {a[14:0], 1'b0};
      default: aluFn = b;
    endcase
  endfunction

  assign i_inst     = imem[envPc];
  assign i_alu_out  = aluFn(i_inst[15:12], o_data1, o_data2);
  assign i_ram_data = ramRd;

  // Fetch stage PC driven by the DUT strobes.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) envPc <= 8'h00;
    else if (o_load_pc) envPc <= o_pc_addr;
    else if (o_inc_pc) envPc <= envPc + 8'h01;
  end

  // Data RAM with synchronous read and write strobe.
  always @(posedge i_clk) begin
    if (fillRam) begin
      for (int k = 0; k < 256; k++) envRam[k] <= ramInit[k];
    end else begin
      if (o_ram_load) envRam[o_ram_addr] <= o_ram_data;
      ramRd <= envRam[o_ram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkStrobes(input string nm, input bit inc, input bit ld, input bit rl, input bit h);
    checkOutput({nm, ".inc_pc"}, 32'(o_inc_pc), 32'(inc));
    checkOutput({nm, ".load_pc"}, 32'(o_load_pc), 32'(ld));
    checkOutput({nm, ".ram_load"}, 32'(o_ram_load), 32'(rl));
    checkOutput({nm, ".halted"}, 32'(o_halted), 32'(h));
  endtask

  task automatic checkZero(input string nm);
    checkStrobes(nm, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({nm, ".data1"}, 32'(o_data1), 32'h0);
    checkOutput({nm, ".data2"}, 32'(o_data2), 32'h0);
    checkOutput({nm, ".pc_addr"}, 32'(o_pc_addr), 32'h0);
    checkOutput({nm, ".ram_addr"}, 32'(o_ram_addr), 32'h0);
    checkOutput({nm, ".ram_data"}, 32'(o_ram_data), 32'h0);
  endtask

  task automatic resetModel();
    for (int k = 0; k < 4; k++) mRegs[k] = 16'h0000;
    mPc = 8'h00;
    mHalted = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic applyReset(input string nm);
    #1 i_rst = 1'b1;
    #1 checkZero(nm);
    @(negedge i_clk);
    i_rst = 1'b0;
    resetModel();
  endtask

  task automatic checkRecord(input string nm, input cycleExp_t e);
    checkStrobes(nm, e.incPc, e.loadPc, e.ramLoad, e.halted);
    if (e.chkData) begin
      checkOutput({nm, ".data1"}, 32'(o_data1), 32'(e.d1));
      checkOutput({nm, ".data2"}, 32'(o_data2), 32'(e.d2));
      checkOutput({nm, ".ram_data"}, 32'(o_ram_data), 32'(e.d1));
      checkOutput({nm, ".pc_addr"}, 32'(o_pc_addr), 32'(e.addr));
      checkOutput({nm, ".ram_addr"}, 32'(o_ram_addr), 32'(e.addr));
    end
  endtask

  // Runs one instruction from the model's PC, cycle by cycle, with random
  // (and optionally forced) stalls; abortAt picks a cycle to reset in.
  task automatic applyStimulus(input int stallPct, input int forcedStall, input int abortAt, output bit aborted);
    logic [15:0] inst;
    logic [3:0]  op;
    int          hi, lo;
    logic [7:0]  c;
    cycleExp_t   recs[$];
    cycleExp_t   r;
    string       nm;
    bit          en;
    int          stalls;

    inst = imem[mPc];
    op = inst[15:12];
    hi = int'(inst[11:10]);
    lo = int'(inst[9:8]);
    c  = inst[7:0];
    aborted = 1'b0;

    r = '{default: 0};
    recs.push_back(r);
    r.chkData = 1'b1;
    r.d1 = mRegs[hi];
    r.d2 = mRegs[lo];
    r.addr = c;
    if (op < 4'h8) r.incPc = 1'b1;
    else if (op == 4'h8) r.incPc = 1'b1;
    else if (op == 4'h9) begin r.incPc = 1'b1; r.ramLoad = 1'b1; end
    else if (op == 4'hA) r.loadPc = 1'b1;
    else if (op == 4'hB) begin
      if (mRegs[hi] == 16'h0) r.loadPc = 1'b1;
      else r.incPc = 1'b1;
    end else if (op != 4'hF) r.incPc = 1'b1;
    recs.push_back(r);
    if (op == 4'h8) begin
      r.incPc = 1'b0;
      recs.push_back(r);
    end

    foreach (recs[k]) begin
      stalls = (k == 1) ? forcedStall : 0;
      nm = $sformatf("pc%02h.%0d", mPc, k);
      forever begin
        if (stalls > 0) begin
          en = 1'b0;
          stalls--;
        end else begin
          en = ($urandom_range(99) < stallPct) ? 1'b0 : 1'b1;
        end
        i_en = en;
        #1;
        if (!en) begin
          checkStrobes({nm, ".stall"}, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
          if (k == 0) checkOutput({nm, ".fetch_pc"}, 32'(envPc), 32'(mPc));
          checkRecord(nm, recs[k]);
          if (k == abortAt) begin
            applyReset({nm, ".reset"});
            aborted = 1'b1;
            return;
          end
        end
        @(negedge i_clk);
        if (en) break;
      end
    end

    if (op < 4'h8) begin
      mRegs[hi] = aluFn(op, mRegs[hi], mRegs[lo]);
      mPc = mPc + 8'h01;
    end else if (op == 4'h8) begin
      mRegs[hi] = mRam[c];
      mPc = mPc + 8'h01;
    end else if (op == 4'h9) begin
      mRam[c] = mRegs[hi];
      mPc = mPc + 8'h01;
    end else if (op == 4'hA) begin
      mPc = c;
    end else if (op == 4'hB) begin
      mPc = (mRegs[hi] == 16'h0) ? c : mPc + 8'h01;
    end else if (op == 4'hF) begin
      mHalted = 1'b1;
    end else begin
      mPc = mPc + 8'h01;
    end
  endtask

  task automatic haltCycles(input int n);
    for (int k = 0; k < n; k++) begin
      i_en = ($urandom_range(99) < 30) ? 1'b0 : 1'b1;
      #1;
      checkStrobes($sformatf("halt%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge i_clk);
    end
  endtask

  // Loads RAM contents while reset is held, then releases reset.
  task automatic startProgram();
    i_rst = 1'b1;
    i_en = 1'b0;
    for (int k = 0; k < 256; k++) mRam[k] = ramInit[k];
    fillRam = 1'b1;
    @(negedge i_clk);
    fillRam = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    resetModel();
  endtask

  initial begin
    bit ab;
    i_rst = 1'b1;
    i_en = 1'b0;
    fillRam = 1'b0;

    // Directed program exercising ALU writeback, store/load, branches, stall, halt.
    for (int k = 0; k < 256; k++) begin
      imem[k] = 16'hC000;
      ramInit[k] = 16'($urandom);
    end
    ramInit[0] = 16'h0003;
    ramInit[1] = 16'h0004;
    ramInit[2] = 16'hBEEF;
    ramInit[3] = 16'h0005;
    imem[0] = 16'h8400;
    imem[1] = 16'h8801;
    imem[2] = 16'h0600;
    imem[3] = 16'h8C02;
    imem[4] = 16'h9C10;
    imem[5] = 16'h8410;
    imem[6] = 16'h4A00;
    imem[7] = 16'hB820;
    imem[8'h20] = 16'h8803;
    imem[8'h21] = 16'hB820;
    imem[8'h22] = 16'h9C10;
    imem[8'h23] = 16'h0400;
    imem[8'h24] = 16'hF000;

    startProgram();
    #1 checkZero("reset");
    @(negedge i_clk);

    for (int n = 0; n < 40 && !mHalted; n++) begin
      applyStimulus(0, (mPc == 8'h22) ? 4 : 0, -1, ab);
    end
    checkOutput("directed.halt_reached", 32'(mHalted), 32'h1);
    haltCycles(20);
    applyReset("halt.reset");

    // Reset in the MEM cycle of the first LOAD, then rerun from PC 0.
    applyStimulus(0, 0, 2, ab);
    for (int n = 0; n < 40 && !mHalted; n++) begin
      applyStimulus(15, 0, -1, ab);
    end
    checkOutput("rerun.halt_reached", 32'(mHalted), 32'h1);
    haltCycles(5);
    applyReset("rerun.reset");

    // Randomized programs with random stalls and occasional mid-instruction resets.
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 256; k++) begin
        int r;
        logic [3:0] op;
        r = $urandom_range(99);
        if (r < 40) op = 4'($urandom_range(7));
        else if (r < 55) op = 4'h8;
        else if (r < 70) op = 4'h9;
        else if (r < 77) op = 4'hA;
        else if (r < 90) op = 4'hB;
        else if (r < 98) op = 4'($urandom_range(14, 12));
        else op = 4'hF;
        imem[k] = {op, 12'($urandom)};
        ramInit[k] = (($urandom_range(3)) == 0) ? 16'h0000 : 16'($urandom);
      end
      startProgram();
      for (int n = 0; n < 250; n++) begin
        int abortAt;
        abortAt = ($urandom_range(99) < 3) ? $urandom_range(2) : -1;
        applyStimulus(20, ($urandom_range(9) == 0) ? 3 : 0, abortAt, ab);
        if (mHalted) begin
          haltCycles(5);
          applyReset("rand.halt_reset");
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_control.md
Name: exec_control

Overview:
- Multi-cycle execute/writeback sequencer placed directly downstream of the instruction fetch stage.
- Consumes the fetched 16-bit instruction and holds the four-entry general register file.
- Drives operands to the ALU, the data-RAM load/address/data inputs, and program-counter increment/load.
- Captures ALU results and RAM read data back into the register file.

Parameters:
- INST_ADDR_WIDTH, 8, width of the program-counter load address.
- DATA_ADDR_WIDTH, 8, width of the data-RAM address; must be ≤ 8, since it is taken from the instruction constant.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_en  input  1  run enable; when low, the FSM and register file hold and all strobes are 0.
- i_inst  input  16  instruction from the fetch stage, valid one cycle after any PC change.
- i_alu_out  input  16  ALU result, combinational from o_data1/o_data2/IR.
- i_ram_data  input  16  data-RAM read data, one-cycle synchronous read.
- o_data1  output  16  ALU operand A = reg[IR[11:10]].
- o_data2  output  16  ALU operand B = reg[IR[9:8]].
- o_inc_pc  output  1  one-cycle PC increment strobe.
- o_load_pc  output  1  one-cycle PC load strobe.
- o_pc_addr  output  INST_ADDR_WIDTH  PC load target = IR[INST_ADDR_WIDTH-1:0].
- o_ram_load  output  1  data-RAM write strobe.
- o_ram_addr  output  DATA_ADDR_WIDTH  RAM address = IR[DATA_ADDR_WIDTH-1:0].
- o_ram_data  output  16  RAM write data = reg[IR[11:10]].
- o_halted  output  1  high while in HALT.

Behaviour:
- Reset (async, any state, including mid-LOAD):
  - All four registers, IR and every output go to 0.
  - FSM goes to FETCH.
  - A RAM write pending in that cycle is aborted; o_ram_load drops immediately.
- Opcode map on IR[15:12]:
  - 0x0–0x7: ALU op, writes reg[hi].
  - 0x8: LOAD, reg[hi] ← ram[const].
  - 0x9: STORE, ram[const] ← reg[hi].
  - 0xA: JMP to const.
  - 0xB: JZ, jump to const if reg[hi]==0.
  - 0xF: HALT.
  - 0xC–0xE: NOP.
  - Here hi = IR[11:10], lo = IR[9:8], const = IR[7:0].
- FETCH (1 cycle): no strobes. On exit, IR ← i_inst. Next state: EXEC.
- EXEC (1 cycle):
  - ALU op: reg[hi] ← i_alu_out at end of cycle; o_inc_pc=1; next FETCH.
  - STORE: o_ram_load=1; o_inc_pc=1; next FETCH.
  - LOAD: RAM address driven, o_ram_load=0; o_inc_pc=1; next MEM.
  - JMP, or JZ taken: o_load_pc=1, o_inc_pc=0; next FETCH.
  - JZ not taken, or NOP: o_inc_pc=1; next FETCH.
  - HALT: no strobes; next HALT.
- MEM (1 cycle, LOAD only): reg[hi] ← i_ram_data at end of cycle; next FETCH.
- HALT: absorbing; leaves only on reset; o_halted=1.
- Timing and strobe rules:
  - Cycles per instruction: ALU/STORE/jump/NOP = 2; LOAD = 3.
  - o_inc_pc and o_load_pc are mutually exclusive and never both 1.
  - Each strobe lasts exactly one cycle per instruction.
- Stall: i_en=0 freezes the state, IR and registers, and forces all strobes to 0. Resuming continues the same state with no repeated or lost strobe.
- Operand hazards:
  - Operands are read combinationally from the register file, so a write is visible in the next instruction's EXEC. No forwarding is needed.
  - hi==lo is legal and both operands read the same register.
- Widths and addressing:
  - All register data is 16-bit; no extension.
  - Address and PC outputs truncate IR to the parameter width; no wrap logic. PC wrap is owned by the fetch stage.

Test Plan:
1. Reset mid-run:
   - Assert i_rst during MEM of a LOAD.
   - Required: all regs 0, o_ram_load=0, FSM in FETCH, o_halted=0.
2. ALU writeback:
   - Preload reg1=0x0003, reg2=0x0004; issue inst 0x0600 with the bench ALU model returning data1+data2.
   - Required: o_data1=3, o_data2=4 in EXEC; reg1=0x0007 on the next FETCH; exactly one o_inc_pc pulse; 2 cycles.
3. LOAD/STORE round trip:
   - STORE 0x9C10 with reg3=0xBEEF.
   - Required: o_ram_load=1, o_ram_addr=0x10, o_ram_data=0xBEEF for one cycle.
   - Then LOAD 0x8410.
   - Required: reg1=0xBEEF after MEM; 3-cycle instruction.
4. Branches:
   - JZ 0xB820 with reg2=0. Required: o_load_pc=1, o_pc_addr=0x20, o_inc_pc=0.
   - Same JZ with reg2=5. Required: o_inc_pc=1, o_load_pc=0.
5. Stall:
   - Hold i_en=0 for 4 cycles during EXEC of a STORE.
   - Required: no strobes while stalled; exactly one o_ram_load pulse after release.
6. HALT:
   - Issue 0xF000.
   - Required: o_halted=1 permanently, no strobes for 20 cycles; i_rst returns the FSM to FETCH.
